// File: rtl/tt_sweep_if.sv
// Bus bundle between the sweep controller and its host/board side.
// The slave modport is the controller; the master modport is whoever drives
// start/abort, presents the board outputs and reads the result store.
interface tt_sweep_if;
    // Control handshake
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        results_valid;

    // Board drive and board response
    logic [3:0]  row;
    logic [9:0]  f_in;

    // Result store readback and signature
    logic [3:0]  rd_addr;
    logic [9:0]  rd_data;
    logic [15:0] signature;

    modport master (
        output start,
        output abort,
        output f_in,
        output rd_addr,
        input  row,
        input  busy,
        input  done,
        input  results_valid,
        input  rd_data,
        input  signature
    );

    modport slave (
        input  start,
        input  abort,
        input  f_in,
        input  rd_addr,
        output row,
        output busy,
        output done,
        output results_valid,
        output rd_data,
        output signature
    );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Sweep controller for the 4-input / 10-output function board.
// Drives rows 0..15 in order, lets each settle for SETTLE cycles, captures
// f_in into a 16-entry store and folds every capture into a rotate/XOR
// signature. The store is read through a registered port with one cycle of
// latency and read-before-write behaviour on a same-cycle capture.
// SETTLE must lie in 1..15 so that SETTLE-1 fits the 4-bit wait counter.
module tt_sweep_ctrl #(
    parameter int unsigned SETTLE = 3
) (
    input logic     clk,
    input logic     rst_n,
    tt_sweep_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StCap
    } state_e;

    localparam logic [3:0] CntLoad = 4'(SETTLE - 1);
    localparam logic [3:0] LastRow = 4'd15;

    state_e      state_q, state_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] sig_q, sig_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        valid_q, valid_d;

    logic [9:0]  mem_q [16];
    logic        mem_we;
    logic [9:0]  rd_data_q;

    // Next-state, counter, signature and store-write decode
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        mem_we  = 1'b0;

        if (bus.abort) begin
            // Abort freezes row, signature and store; only the sweep stops.
            state_d = StIdle;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_d = StWait;
                        row_d   = 4'd0;
                        cnt_d   = CntLoad;
                        sig_d   = 16'd0;
                        busy_d  = 1'b1;
                        valid_d = 1'b0;
                    end
                end

                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_d = StCap;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end

                StCap: begin
                    mem_we = 1'b1;
                    sig_d  = {sig_q[14:0], sig_q[15]} ^ {6'b0, bus.f_in};
                    if (row_q != LastRow) begin
                        state_d = StWait;
                        row_d   = row_q + 4'd1;
                        cnt_d   = CntLoad;
                    end else begin
                        // Row stays at 15 after the last capture.
                        state_d = StIdle;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        valid_d = 1'b1;
                    end
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            row_q   <= 4'd0;
            cnt_q   <= 4'd0;
            sig_q   <= 16'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    // Result store; reset clears every entry so a mid-sweep reset leaves no stale data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 10'd0;
            end
        end else if (mem_we) begin
            mem_q[row_q] <= bus.f_in;
        end
    end

    // Registered readback; sees the pre-write entry on a same-edge capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= 10'd0;
        end else begin
            rd_data_q <= mem_q[bus.rd_addr];
        end
    end

    assign bus.row           = row_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.results_valid = valid_q;
    assign bus.signature     = sig_q;
    assign bus.rd_data       = rd_data_q;

endmodule
